// File: rtl/mips_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Contents: loader state enum, stream field widths, byte-lane order and a lane helper.
package mips_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StLoad,
        StCsum,
        StDone,
        StError
    } load_state_e;

    localparam int unsigned HdrWidth  = 16;
    localparam int unsigned CsumWidth = 8;

    // Words arrive MSB first: byte index 0 lands in lane 3 (bits [31:24]).
    localparam bit LaneMsbFirst = 1'b1;

    // Map a byte index within a word onto its 8-bit lane number.
    function automatic logic [1:0] lane_of(input logic [1:0] idx);
        return LaneMsbFirst ? (2'd3 - idx) : idx;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of the loader.
// slave  : loader view (consumes rx bytes, drives the imem write port).
// master : host/environment view (drives rx bytes, observes the write port).
// Signals: rx_data/rx_valid/rx_ready byte handshake; imem_we/imem_addr/imem_wdata write port.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/loader_word_assembler.sv
// Packs accepted payload bytes into 32-bit words and emits a registered one-cycle
// word_valid strobe in the cycle after the 4th byte of each word is accepted.
// Ports: clk, reset (async, active-low), clear (restart at byte 0), accept/data (byte in),
//        word_valid/word (assembled word out; word holds until the next word completes).
module loader_word_assembler
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] lanes_q, lanes_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;
    logic [4:0]  base;

    always_comb begin
        idx_d   = idx_q;
        lanes_d = lanes_q;
        word_d  = word_q;
        valid_d = 1'b0;
        base    = {lane_of(idx_q), 3'b000};
        if (clear) begin
            idx_d   = '0;
            lanes_d = '0;
        end else if (accept) begin
            lanes_d[base +: 8] = data;
            idx_d              = idx_q + 2'd1;
            // Capture the completed word including the byte arriving now.
            if (idx_q == 2'd3) begin
                word_d  = lanes_d;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q   <= '0;
            lanes_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_valid = valid_q;
    assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses [N (16b BE)] [4N payload bytes] [8b checksum], writes big-endian
// words to instruction memory at addresses 0..N-1 and holds the core in reset until a
// complete, checksum-valid image is in place.
// Ports: clk, reset (async, active-low), start (load request pulse), bus (slave modport:
//        rx byte handshake + imem write port), core_reset, busy, done, error.
module imem_loader
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    imem_loader_if.slave     bus,
    output logic             core_reset,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int unsigned MaxWords = 2 ** ADDR_W;

    typedef logic [ADDR_W:0]   wcnt_t;   // holds 0..2^ADDR_W
    typedef logic [ADDR_W+2:0] bcnt_t;   // holds 0..4*2^ADDR_W-1

    load_state_e          state_q, state_d;
    logic [7:0]           hdr_hi_q, hdr_hi_d;
    logic                 hdr_idx_q, hdr_idx_d;
    wcnt_t                len_q, len_d;
    bcnt_t                byte_cnt_q, byte_cnt_d;
    wcnt_t                word_cnt_q, word_cnt_d;
    logic [CsumWidth-1:0] sum_q, sum_d;
    logic                 core_reset_q, core_reset_d;

    logic                 accept;
    logic                 load_accept;
    logic                 clear;
    logic [HdrWidth-1:0]  hdr_n;
    logic                 len_ok;
    bcnt_t                last_byte;
    logic                 word_valid;
    logic [31:0]          word;

    assign accept    = bus.rx_valid & bus.rx_ready;
    assign hdr_n     = {hdr_hi_q, bus.rx_data};
    assign len_ok    = (hdr_n != '0) && ({16'd0, hdr_n} <= MaxWords);
    assign last_byte = {len_q, 2'b00} - bcnt_t'(1);

    always_comb begin
        state_d     = state_q;
        hdr_hi_d    = hdr_hi_q;
        hdr_idx_d   = hdr_idx_q;
        len_d       = len_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        sum_d       = sum_q;
        load_accept = 1'b0;
        clear       = 1'b0;

        // The word index advances after each write; the final write may land in CSUM/DONE.
        if (word_valid) begin
            word_cnt_d = word_cnt_q + wcnt_t'(1);
        end

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d    = StHdr;
                    clear      = 1'b1;
                    hdr_idx_d  = 1'b0;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    sum_d      = '0;
                end
            end
            StHdr: begin
                if (accept) begin
                    if (!hdr_idx_q) begin
                        hdr_hi_d  = bus.rx_data;
                        hdr_idx_d = 1'b1;
                    end else begin
                        hdr_idx_d = 1'b0;
                        if (len_ok) begin
                            len_d   = hdr_n[ADDR_W:0];
                            state_d = StLoad;
                        end else begin
                            state_d = StError;
                        end
                    end
                end
            end
            StLoad: begin
                if (accept) begin
                    load_accept = 1'b1;
                    sum_d       = sum_q + bus.rx_data;
                    byte_cnt_d  = byte_cnt_q + bcnt_t'(1);
                    if (byte_cnt_q == last_byte) begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    state_d = (bus.rx_data == sum_q) ? StDone : StError;
                end
            end
            default: state_d = StIdle;
        endcase

        core_reset_d = (state_d != StDone);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            hdr_hi_q     <= '0;
            hdr_idx_q    <= 1'b0;
            len_q        <= '0;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            sum_q        <= '0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            hdr_hi_q     <= hdr_hi_d;
            hdr_idx_q    <= hdr_idx_d;
            len_q        <= len_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            sum_q        <= sum_d;
            core_reset_q <= core_reset_d;
        end
    end

    loader_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .accept     (load_accept),
        .data       (bus.rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    assign busy           = (state_q == StHdr) || (state_q == StLoad) || (state_q == StCsum);
    assign bus.rx_ready   = busy;
    assign done           = (state_q == StDone);
    assign error          = (state_q == StError);
    assign core_reset     = core_reset_q;
    assign bus.imem_we    = word_valid;
    assign bus.imem_addr  = word_cnt_q[ADDR_W-1:0];
    assign bus.imem_wdata = word;

endmodule
